vram_write_port: RTL and testbench

CPU-facing write front end for the GPU video memory. Converts byte-wide register writes from the host bus into an auto-incrementing address pointer plus a small write FIFO, and drains that FIFO into the memory block's write port (`write_addr` / `write_enable` / `write_data`) whenever the memory side signals it can accept a write. Sits directly upstream of the video memory write port; the memory's read port stays owned by the display pipeline.

---
 rtl/vram_write_port_if.sv | 42 ++++
 rtl/vram_write_port.sv | 133 +++++++++++++
 tb/tb_vram_write_port.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_port_if.sv
// -----------------------------------------------------------------------------
// vram_write_port_if
//   Bundles the host register bus, the memory write port and the status flags
//   of vram_write_port.
//   master : host side (drives register writes and mem_ready, reads status)
//   slave  : vram_write_port itself
//   Signals:
//     reg_sel[1:0]    register select (0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL)
//     reg_write       one-cycle register write strobe
//     reg_wdata[7:0]  register write data
//     mem_ready       memory write port can take a write this cycle
//     write_addr      memory write address
//     write_enable    memory write enable (registered)
//     write_data[7:0] memory write data (registered)
//     fifo_empty      no pending writes
//     fifo_full       write FIFO holds FIFO_DEPTH entries
//     overflow        sticky: a DATA write was dropped
// -----------------------------------------------------------------------------
interface vram_write_port_if #(
  parameter int ADDRESS_WIDTH = 10
);
  logic [1:0]               reg_sel;
  logic                     reg_write;
  logic [7:0]               reg_wdata;
  logic                     mem_ready;
  logic [ADDRESS_WIDTH-1:0] write_addr;
  logic                     write_enable;
  logic [7:0]               write_data;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     overflow;

  modport master (
    output reg_sel, reg_write, reg_wdata, mem_ready,
    input  write_addr, write_enable, write_data, fifo_empty, fifo_full, overflow
  );

  modport slave (
    input  reg_sel, reg_write, reg_wdata, mem_ready,
    output write_addr, write_enable, write_data, fifo_empty, fifo_full, overflow
  );
endinterface

// File: rtl/vram_write_port.sv
// -----------------------------------------------------------------------------
// vram_write_port
//   CPU-facing write front end for the video memory. Byte-wide register writes
//   set an auto-incrementing address pointer; DATA writes queue {addr, data}
//   into a small FIFO that drains into the memory write port whenever
//   mem_ready is high, one write per cycle.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    vram_write_port_if.slave (register bus, memory port, status)
// -----------------------------------------------------------------------------
module vram_write_port #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  vram_write_port_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HI_W  = ADDRESS_WIDTH - 8;

  typedef enum logic [1:0] {
    SEL_ADDR_LO = 2'd0,
    SEL_ADDR_HI = 2'd1,
    SEL_DATA    = 2'd2,
    SEL_CTRL    = 2'd3
  } reg_sel_e;

  logic [ADDRESS_WIDTH-1:0] addr_ptr;
  logic [2:0]               incr;

  logic [ADDRESS_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]               fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;

  logic data_wr;
  logic ctrl_wr;
  logic do_pop;
  logic do_push;
  logic drop;

  // Bits 6:3 of CTRL and the ADDR_HI bits above the pointer are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    data_wr    = bus.reg_write && (bus.reg_sel == SEL_DATA);
    ctrl_wr    = bus.reg_write && (bus.reg_sel == SEL_CTRL);
    do_pop     = !bus.fifo_empty && bus.mem_ready;
    // A push into a full FIFO still fits when the head leaves this same cycle.
    do_push    = data_wr && (!bus.fifo_full || do_pop);
    drop       = data_wr && !do_push;
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Register file: address pointer, increment and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr     <= '0;
      incr         <= 3'd1;
      bus.overflow <= 1'b0;
    end else begin
      if (bus.reg_write) begin
        case (bus.reg_sel)
          SEL_ADDR_LO: addr_ptr[7:0] <= bus.reg_wdata;
          SEL_ADDR_HI: addr_ptr[ADDRESS_WIDTH-1:8] <= bus.reg_wdata[HI_W-1:0];
          SEL_DATA:    if (do_push) addr_ptr <= addr_ptr + ADDRESS_WIDTH'(incr);
          SEL_CTRL:    incr <= bus.reg_wdata[2:0];
          default:     ;
        endcase
      end
      // A clear arriving with a drop wins over the set.
      if (ctrl_wr && bus.reg_wdata[7]) begin
        bus.overflow <= 1'b0;
      end else if (drop) begin
        bus.overflow <= 1'b1;
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the count alone decides
  // which entries are valid, so reset discards them without clearing the RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_addr[wr_ptr] <= addr_ptr;
      fifo_data[wr_ptr] <= bus.reg_wdata;
    end
  end

  // FIFO control and the registered memory write port. The async reset drops
  // write_enable immediately, mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bus.fifo_empty   <= 1'b1;
      bus.fifo_full    <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.write_addr   <= '0;
      bus.write_data   <= '0;
    end else begin
      count            <= count_next;
      bus.fifo_empty   <= (count_next == '0);
      bus.fifo_full    <= (count_next == CNT_W'(FIFO_DEPTH));
      bus.write_enable <= do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        bus.write_addr <= fifo_addr[rd_ptr];
        bus.write_data <= fifo_data[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_vram_write_port.sv
// -----------------------------------------------------------------------------
// tb_vram_write_port
//   Directed bench for vram_write_port (ADDRESS_WIDTH 10, FIFO_DEPTH 4).
//   Inputs change and outputs are sampled on the falling clock edge; each
//   "apply" spans exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_vram_write_port;

  localparam logic [1:0] LO = 2'd0;
  localparam logic [1:0] HI = 2'd1;
  localparam logic [1:0] DT = 2'd2;
  localparam logic [1:0] CT = 2'd3;

  typedef struct {
    logic       w;
    logic [1:0] sel;
    logic [7:0] d;
    logic       rdy;
    logic       we;
    logic [9:0] addr;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic       ovf;
  } vec_t;

  localparam int NV = 28;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs [NV];

  vram_write_port_if #(.ADDRESS_WIDTH(10)) bus ();

  vram_write_port #(.ADDRESS_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic w, input logic [1:0] sel, input logic [7:0] d, input logic rdy);
    bus.reg_write = w;
    bus.reg_sel   = sel;
    bus.reg_wdata = d;
    bus.mem_ready = rdy;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic we, input logic [9:0] addr,
                            input logic [7:0] data, input logic empty, input logic full,
                            input logic ovf);
    check({tag, ".we"},    32'(bus.write_enable), 32'(we));
    check({tag, ".empty"}, 32'(bus.fifo_empty),   32'(empty));
    check({tag, ".full"},  32'(bus.fifo_full),    32'(full));
    check({tag, ".ovf"},   32'(bus.overflow),     32'(ovf));
    if (we) begin
      check({tag, ".addr"}, 32'(bus.write_addr), 32'(addr));
      check({tag, ".data"}, 32'(bus.write_data), 32'(data));
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sel, input logic [7:0] d,
                              input logic rdy, input logic we, input logic [9:0] addr,
                              input logic [7:0] data, input logic empty);
    vec_t v;
    v.w = w; v.sel = sel; v.d = d; v.rdy = rdy;
    v.we = we; v.addr = addr; v.data = data; v.empty = empty;
    v.full = 1'b0; v.ovf = 1'b0;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // Basic write: pointer 0x110, one pulse two edges after the DATA strobe.
    vecs[0]  = mk(1, LO, 8'h10, 1, 0, 10'h000, 8'h00, 1);
    vecs[1]  = mk(1, HI, 8'h01, 1, 0, 10'h000, 8'h00, 1);
    vecs[2]  = mk(1, DT, 8'hAB, 1, 0, 10'h000, 8'h00, 0);
    vecs[3]  = mk(0, LO, 8'h00, 1, 1, 10'h110, 8'hAB, 1);
    vecs[4]  = mk(0, LO, 8'h00, 1, 0, 10'h000, 8'h00, 1);
    // Increment 1 across the wrap: 0x3FE, 0x3FF, 0x000.
    vecs[5]  = mk(1, LO, 8'hFE, 1, 0, 10'h000, 8'h00, 1);
    vecs[6]  = mk(1, HI, 8'h03, 1, 0, 10'h000, 8'h00, 1);
    vecs[7]  = mk(1, CT, 8'h01, 1, 0, 10'h000, 8'h00, 1);
    vecs[8]  = mk(1, DT, 8'h01, 1, 0, 10'h000, 8'h00, 0);
    vecs[9]  = mk(1, DT, 8'h02, 1, 1, 10'h3FE, 8'h01, 0);
    vecs[10] = mk(1, DT, 8'h03, 1, 1, 10'h3FF, 8'h02, 0);
    vecs[11] = mk(0, LO, 8'h00, 1, 1, 10'h000, 8'h03, 1);
    vecs[12] = mk(0, LO, 8'h00, 1, 0, 10'h000, 8'h00, 1);
    // Increment 0: both writes land on 0x020.
    vecs[13] = mk(1, CT, 8'h00, 1, 0, 10'h000, 8'h00, 1);
    vecs[14] = mk(1, LO, 8'h20, 1, 0, 10'h000, 8'h00, 1);
    vecs[15] = mk(1, DT, 8'hA1, 1, 0, 10'h000, 8'h00, 0);
    vecs[16] = mk(1, DT, 8'hA2, 1, 1, 10'h020, 8'hA1, 0);
    vecs[17] = mk(0, LO, 8'h00, 1, 1, 10'h020, 8'hA2, 1);
    // Increment 4: 0x020, 0x024, 0x028.
    vecs[18] = mk(1, CT, 8'h04, 1, 0, 10'h000, 8'h00, 1);
    vecs[19] = mk(1, DT, 8'hB0, 1, 0, 10'h000, 8'h00, 0);
    vecs[20] = mk(1, DT, 8'hB1, 1, 1, 10'h020, 8'hB0, 0);
    vecs[21] = mk(1, DT, 8'hB2, 1, 1, 10'h024, 8'hB1, 0);
    vecs[22] = mk(0, LO, 8'h00, 1, 1, 10'h028, 8'hB2, 1);
    vecs[23] = mk(0, LO, 8'h00, 1, 0, 10'h000, 8'h00, 1);
    // ADDR_HI excess bits ignored: 0xFD keeps only 2'b01 -> pointer 0x12C.
    vecs[24] = mk(1, HI, 8'hFD, 1, 0, 10'h000, 8'h00, 1);
    vecs[25] = mk(1, CT, 8'h01, 1, 0, 10'h000, 8'h00, 1);
    vecs[26] = mk(1, DT, 8'hC5, 1, 0, 10'h000, 8'h00, 0);
    vecs[27] = mk(0, LO, 8'h00, 1, 1, 10'h12C, 8'hC5, 1);

    bus.reg_write = 1'b0;
    bus.reg_sel   = 2'd0;
    bus.reg_wdata = 8'h00;
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0);
    check("reset.addr", 32'(bus.write_addr), 32'h0);
    check("reset.data", 32'(bus.write_data), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].w, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                 vecs[i].empty, vecs[i].full, vecs[i].ovf);
    end

    // Backpressure: four pushes at 0x040.. with mem_ready low, then drain.
    apply(1, LO, 8'h40, 1);
    apply(1, HI, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      apply(1, DT, 8'hD0 + 8'(i), 0);
      expect_out($sformatf("bp_push%0d", i), 1'b0, 10'h0, 8'h0, 1'b0, i == 3, 1'b0);
    end
    apply(0, LO, 8'h00, 0);
    expect_out("bp_hold", 1'b0, 10'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(0, LO, 8'h00, 1);
      expect_out($sformatf("bp_pop%0d", i), 1'b1, 10'h040 + 10'(i), 8'hD0 + 8'(i),
                 i == 3, 1'b0, 1'b0);
    end
    apply(0, LO, 8'h00, 1);
    expect_out("bp_idle", 1'b0, 10'h0, 8'h0, 1'b1, 1'b0, 1'b0);

    // Overflow: fill 0x044..0x047, drop 0x55, clear with CTRL 0x81.
    for (int i = 0; i < 4; i++) begin
      apply(1, DT, 8'hE0 + 8'(i), 0);
    end
    apply(1, DT, 8'h55, 0);
    expect_out("ovf_drop", 1'b0, 10'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    apply(1, CT, 8'h81, 0);
    expect_out("ovf_clear", 1'b0, 10'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(0, LO, 8'h00, 1);
      expect_out($sformatf("ovf_pop%0d", i), 1'b1, 10'h044 + 10'(i), 8'hE0 + 8'(i),
                 i == 3, 1'b0, 1'b0);
    end
    // Pointer was not advanced by the drop, and increment is back to 1.
    apply(1, DT, 8'h66, 1);
    expect_out("ovf_ptr0", 1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    apply(1, DT, 8'h67, 1);
    expect_out("ovf_ptr1", 1'b1, 10'h048, 8'h66, 1'b0, 1'b0, 1'b0);
    apply(0, LO, 8'h00, 1);
    expect_out("ovf_ptr2", 1'b1, 10'h049, 8'h67, 1'b1, 1'b0, 1'b0);

    // Full FIFO with simultaneous pop and push: push accepted, count stays 4.
    for (int i = 0; i < 4; i++) begin
      apply(1, DT, 8'hF0 + 8'(i), 0);
    end
    apply(1, DT, 8'hF4, 1);
    expect_out("sim_pushpop", 1'b1, 10'h04A, 8'hF0, 1'b0, 1'b1, 1'b0);
    apply(0, LO, 8'h00, 0);
    expect_out("sim_hold", 1'b0, 10'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(0, LO, 8'h00, 1);
      expect_out($sformatf("sim_pop%0d", i), 1'b1, 10'h04B + 10'(i), 8'hF1 + 8'(i),
                 i == 3, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a drain.
    apply(1, DT, 8'h11, 0);
    apply(1, DT, 8'h22, 0);
    apply(0, LO, 8'h00, 1);
    expect_out("ar_pre", 1'b1, 10'h04F, 8'h11, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("ar_async", 1'b0, 10'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    check("ar_async.addr", 32'(bus.write_addr), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply(0, LO, 8'h00, 1);
      expect_out($sformatf("ar_after%0d", i), 1'b0, 10'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    end
    // Pointer reset to 0 with increment 1.
    apply(1, DT, 8'h77, 1);
    apply(0, LO, 8'h00, 1);
    expect_out("ar_ptr", 1'b1, 10'h000, 8'h77, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
